serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing diff = a - b, one bit per clock, LSB first.
- Instantiates a single one-bit full-subtractor cell and feeds its borrow back through a flip-flop.
- Uses a start/busy/done handshake.
- The arithmetic stage for the chapter's sequential datapath examples; trades WIDTH cycles of latency for one subtractor cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in SHIFT state
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH
- borrow_out  output  1  registered final borrow; 1 iff a < b (unsigned)

Behaviour:
- Clock/reset: single clock clk. Reset rst_n is synchronous, active-low, and checked before all other logic on the rising edge.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0; internal shift registers, bit counter and borrow flop = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: load a_sr<=a, b_sr<=b, res_sr<=0, borrow flop<=0, cnt<=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), each edge:
  - Cell inputs x=a_sr[0], y=b_sr[0], z=borrow flop.
  - Cell outputs: D = x^y^z; B = (~x&y) | (~x&z) | (y&z).
  - Register updates: a_sr and b_sr shift right by 1; res_sr <= {D, res_sr[WIDTH-1:1]}; borrow flop <= B; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (edge k+WIDTH): diff <= {D, res_sr[WIDTH-1:1]}, borrow_out <= B, go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start accepted at edge k; done is high during the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- diff and borrow_out change only at completion. They hold the previous result through a later SHIFT phase and until the next completion.
- start while in SHIFT or DONE is ignored. No queueing; a and b are not resampled.
- start held high continuously: a new operation is accepted on each return to IDLE.
- Reset asserted mid-SHIFT: operation aborts, all reset values apply, and no done pulse is produced.
- busy and done are decoded from registered state and are never both high.
- Counter width is $clog2(WIDTH); the counter never wraps past WIDTH-1.

Decomposition:
- Package serial_sub_pkg: state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- Sub-module sub_bit_cell: purely combinational (x, y, z -> d, b) one-bit full subtractor. Instantiated once.
- All sequencing lives in serial_subtractor.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, start 1 cycle -> busy 8 cycles, done pulse at cycle 9 after accept, diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1. a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0.
- Accept a=8'h10, b=8'h01; pulse start with a=8'hAA during SHIFT -> ignored, result diff=8'h0F. Previous diff held on the output until completion.
- Assert rst_n=0 at SHIFT cycle 4 -> next edge: busy=0, diff=0, borrow_out=0, no done pulse. A fresh start then completes normally.
- Random sweep, 1000 operand pairs, start held high -> every done pulse matches reference (a-b) mod 256 and (a<b). Done pulses are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: d = x - y - z, b = borrow out.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic b
);

  assign d = x ^ y ^ z;
  assign b = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with a
// start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_b;

  sub_bit_cell u_cell (
    .x (a_q[0]),
    .y (b_q[0]),
    .z (brw_q),
    .d (cell_d),
    .b (cell_b)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        brw_d = cell_b;
        // Counter parks on LAST rather than wrapping; IDLE reloads it anyway.
        if (cnt_q == LAST) begin
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_b;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
